haar_cascade_sequencer: RTL and testbench

//  Drives the Haar feature classifier for one detection window: streams stage headers and

---
 rtl/haar_pkg.sv | 34 +++
 rtl/haar_cascade_sequencer_loader.sv | 34 +++
 rtl/haar_cascade_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_haar_cascade_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/haar_pkg.sv
// Shared definitions for the Haar cascade sequencer: FSM states, memory
// layout sizes and the word positions inside one feature record.
package haar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_EVAL,
    S_CHECK,
    S_FINISH
  } state_t;

  localparam int REC_WORDS = 15;
  localparam int HDR_WORDS = 2;

  // Word order of a feature record as it sits in cascade memory
  localparam int W_A1    = 0;
  localparam int W_B1    = 1;
  localparam int W_C1    = 2;
  localparam int W_D1    = 3;
  localparam int W_A2    = 4;
  localparam int W_B2    = 5;
  localparam int W_C2    = 6;
  localparam int W_D2    = 7;
  localparam int W_A3    = 8;
  localparam int W_B3    = 9;
  localparam int W_C3    = 10;
  localparam int W_D3    = 11;
  localparam int W_THR   = 12;
  localparam int W_LEFT  = 13;
  localparam int W_RIGHT = 14;

endpackage

// File: rtl/haar_cascade_sequencer_loader.sv
// Feature record loader: counts returning memory words of a record and
// steers each one into its own output register. record_loaded marks the
// cycle in which the final (right leaf) word is being written.
module haar_record_loader
  import haar_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DATA_WIDTH-1:0]                 data,
  input  logic                                  data_vld,
  output logic [REC_WORDS-1:0][DATA_WIDTH-1:0]  words,
  output logic                                  record_loaded
);

  logic [3:0] word_cnt;

  assign record_loaded = data_vld && (word_cnt == 4'(REC_WORDS - 1));

  // Word counter and 15-way demux into the record registers
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt <= '0;
      words    <= '0;
    end else if (data_vld) begin
      for (int k = 0; k < REC_WORDS; k++) begin
        if (word_cnt == 4'(k)) words[k] <= data;
      end
      word_cnt <= record_loaded ? 4'd0 : word_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/haar_cascade_sequencer.sv
// Haar cascade sequencer for one detection window. Streams stage headers
// and feature records out of cascade memory, presents each feature to the
// combinational classifier, accumulates the returned haar values per stage
// and compares each stage sum against the stage threshold.
// Build option: define HAAR_EARLY_EXIT_EN to stop at the first failing
// stage; otherwise every stage is evaluated and latency is data-independent.
module haar_cascade_sequencer
  import haar_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_STAGES = 4,
  parameter int STAGE_W    = 4,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_face,
  output logic [STAGE_W-1:0]    o_fail_stage,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [DATA_WIDTH-1:0] o_rect_A_1,
  output logic [DATA_WIDTH-1:0] o_rect_B_1,
  output logic [DATA_WIDTH-1:0] o_rect_C_1,
  output logic [DATA_WIDTH-1:0] o_rect_D_1,
  output logic [DATA_WIDTH-1:0] o_rect_A_2,
  output logic [DATA_WIDTH-1:0] o_rect_B_2,
  output logic [DATA_WIDTH-1:0] o_rect_C_2,
  output logic [DATA_WIDTH-1:0] o_rect_D_2,
  output logic [DATA_WIDTH-1:0] o_rect_A_3,
  output logic [DATA_WIDTH-1:0] o_rect_B_3,
  output logic [DATA_WIDTH-1:0] o_rect_C_3,
  output logic [DATA_WIDTH-1:0] o_rect_D_3,
  output logic [DATA_WIDTH-1:0] o_threshold,
  output logic [DATA_WIDTH-1:0] o_left_word,
  output logic [DATA_WIDTH-1:0] o_right_word,
  input  logic [DATA_WIDTH-1:0] i_haarvalue
);

  state_t                 state, state_nxt;
  logic [1:0]             hdr_cnt;
  logic [3:0]             load_cnt;
  logic [DATA_WIDTH-1:0]  feat_cnt;
  logic [DATA_WIDTH-1:0]  feat_cnt_inc;
  logic [DATA_WIDTH-1:0]  n_feat;
  logic [DATA_WIDTH-1:0]  stage_thr;
  logic [ACC_WIDTH-1:0]   acc;
  logic [STAGE_W-1:0]     stage_idx;
  logic [STAGE_W-1:0]     fail_idx;
  logic                   failed;
  logic [ADDR_WIDTH-1:0]  addr;
  logic                   mem_rd;
  logic                   rd_vld_p1;
  logic                   rd_load_p1;
  logic                   record_loaded;
  logic                   stage_pass;
  logic                   last_stage;
  logic                   face_nxt;
  logic [STAGE_W-1:0]     fail_stage_nxt;
  logic [REC_WORDS-1:0][DATA_WIDTH-1:0] rec_words;

  // Saturating accumulate of one haar value into the stage sum
  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] sum;
    sum = {1'b0, a} + (ACC_WIDTH+1)'(b);
    return sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
  endfunction

  assign feat_cnt_inc   = feat_cnt + 1'b1;
  assign stage_pass     = acc > ACC_WIDTH'(stage_thr);
  assign last_stage     = (stage_idx == STAGE_W'(NUM_STAGES - 1));
  assign face_nxt       = !failed && stage_pass;
  assign fail_stage_nxt = failed ? fail_idx :
                          (!stage_pass ? stage_idx : STAGE_W'(NUM_STAGES));

  assign o_mem_rd   = mem_rd;
  assign o_mem_addr = addr;
  assign o_busy     = (state != S_IDLE) && (state != S_FINISH);
  assign o_done     = (state == S_FINISH);

  assign o_rect_A_1   = rec_words[W_A1];
  assign o_rect_B_1   = rec_words[W_B1];
  assign o_rect_C_1   = rec_words[W_C1];
  assign o_rect_D_1   = rec_words[W_D1];
  assign o_rect_A_2   = rec_words[W_A2];
  assign o_rect_B_2   = rec_words[W_B2];
  assign o_rect_C_2   = rec_words[W_C2];
  assign o_rect_D_2   = rec_words[W_D2];
  assign o_rect_A_3   = rec_words[W_A3];
  assign o_rect_B_3   = rec_words[W_B3];
  assign o_rect_C_3   = rec_words[W_C3];
  assign o_rect_D_3   = rec_words[W_D3];
  assign o_threshold  = rec_words[W_THR];
  assign o_left_word  = rec_words[W_LEFT];
  assign o_right_word = rec_words[W_RIGHT];

  haar_record_loader #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_loader (
    .clk           (clk),
    .reset         (reset),
    .data          (i_mem_data),
    .data_vld      (rd_load_p1),
    .words         (rec_words),
    .record_loaded (record_loaded)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and read strobe
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) state_nxt = S_HDR;
      end
      S_HDR: begin
        mem_rd = (hdr_cnt < 2'(HDR_WORDS));
        if (hdr_cnt == 2'(HDR_WORDS))
          state_nxt = (n_feat == '0) ? S_CHECK : S_LOAD;
      end
      S_LOAD: begin
        mem_rd = (load_cnt < 4'(REC_WORDS));
        if (record_loaded) state_nxt = S_EVAL;
      end
      S_EVAL: begin
        state_nxt = (feat_cnt_inc == n_feat) ? S_CHECK : S_LOAD;
      end
      S_CHECK: begin
`ifdef HAAR_EARLY_EXIT_EN
        state_nxt = (last_stage || !stage_pass) ? S_FINISH : S_HDR;
`else
        state_nxt = last_stage ? S_FINISH : S_HDR;
`endif
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Read pipeline: marks which cycles carry returning memory data
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_p1  <= 1'b0;
      rd_load_p1 <= 1'b0;
    end else begin
      rd_vld_p1  <= mem_rd;
      rd_load_p1 <= mem_rd && (state == S_LOAD);
    end
  end

  // Address, sequencing counters, header capture, accumulator and results
  always_ff @(posedge clk) begin
    if (reset) begin
      addr         <= '0;
      hdr_cnt      <= '0;
      load_cnt     <= '0;
      feat_cnt     <= '0;
      n_feat       <= '0;
      stage_thr    <= '0;
      acc          <= '0;
      stage_idx    <= '0;
      fail_idx     <= '0;
      failed       <= 1'b0;
      o_face       <= 1'b0;
      o_fail_stage <= '0;
    end else begin
      if (mem_rd) addr <= addr + 1'b1;

      hdr_cnt  <= (state == S_HDR)  ? hdr_cnt + 2'd1 : 2'd0;
      load_cnt <= (state == S_LOAD) ? ((load_cnt == 4'(REC_WORDS)) ? load_cnt : load_cnt + 4'd1)
                                    : 4'd0;

      case (state)
        S_IDLE: begin
          if (i_start) begin
            addr      <= '0;
            stage_idx <= '0;
            fail_idx  <= '0;
            failed    <= 1'b0;
            o_face    <= 1'b0;
          end
        end
        S_HDR: begin
          acc      <= '0;
          feat_cnt <= '0;
          if (rd_vld_p1 && hdr_cnt == 2'd1) n_feat    <= i_mem_data;
          if (rd_vld_p1 && hdr_cnt == 2'd2) stage_thr <= i_mem_data;
        end
        S_EVAL: begin
          acc      <= sat_add(acc, i_haarvalue);
          feat_cnt <= feat_cnt_inc;
        end
        S_CHECK: begin
          if (!stage_pass && !failed) begin
            failed   <= 1'b1;
            fail_idx <= stage_idx;
          end
          stage_idx <= stage_idx + 1'b1;
          if (state_nxt == S_FINISH) begin
            o_face       <= face_nxt;
            o_fail_stage <= fail_stage_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_haar_cascade_sequencer.sv
// Directed bench for haar_cascade_sequencer. Two instances: a 4-stage
// cascade with a 16-bit accumulator and a 1-stage cascade with an 8-bit
// accumulator. Each has a 1-cycle-latency memory model and a small
// classifier: v = A1-B1-C1+D1, value = (v > threshold) ? right : left.
module tb_haar_cascade_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_a, start_b;

  logic        busy_a, done_a, face_a, rd_a;
  logic [3:0]  fs_a;
  logic [11:0] addr_a;
  logic [7:0]  mdata_a, haar_a, v_a;
  logic [7:0]  w0 [15];
  logic [7:0]  mem_a [0:4095];

  logic        busy_b, done_b, face_b, rd_b;
  logic [0:0]  fs_b;
  logic [11:0] addr_b;
  logic [7:0]  mdata_b, haar_b, v_b;
  logic [7:0]  w1 [15];
  logic [7:0]  mem_b [0:4095];

  haar_cascade_sequencer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(12), .NUM_STAGES(4), .STAGE_W(4), .ACC_WIDTH(16)
  ) dut_a (
    .clk(clk), .reset(reset), .i_start(start_a), .o_busy(busy_a), .o_done(done_a),
    .o_face(face_a), .o_fail_stage(fs_a), .o_mem_addr(addr_a), .o_mem_rd(rd_a),
    .i_mem_data(mdata_a),
    .o_rect_A_1(w0[0]), .o_rect_B_1(w0[1]), .o_rect_C_1(w0[2]), .o_rect_D_1(w0[3]),
    .o_rect_A_2(w0[4]), .o_rect_B_2(w0[5]), .o_rect_C_2(w0[6]), .o_rect_D_2(w0[7]),
    .o_rect_A_3(w0[8]), .o_rect_B_3(w0[9]), .o_rect_C_3(w0[10]), .o_rect_D_3(w0[11]),
    .o_threshold(w0[12]), .o_left_word(w0[13]), .o_right_word(w0[14]),
    .i_haarvalue(haar_a)
  );

  haar_cascade_sequencer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(12), .NUM_STAGES(1), .STAGE_W(1), .ACC_WIDTH(8)
  ) dut_b (
    .clk(clk), .reset(reset), .i_start(start_b), .o_busy(busy_b), .o_done(done_b),
    .o_face(face_b), .o_fail_stage(fs_b), .o_mem_addr(addr_b), .o_mem_rd(rd_b),
    .i_mem_data(mdata_b),
    .o_rect_A_1(w1[0]), .o_rect_B_1(w1[1]), .o_rect_C_1(w1[2]), .o_rect_D_1(w1[3]),
    .o_rect_A_2(w1[4]), .o_rect_B_2(w1[5]), .o_rect_C_2(w1[6]), .o_rect_D_2(w1[7]),
    .o_rect_A_3(w1[8]), .o_rect_B_3(w1[9]), .o_rect_C_3(w1[10]), .o_rect_D_3(w1[11]),
    .o_threshold(w1[12]), .o_left_word(w1[13]), .o_right_word(w1[14]),
    .i_haarvalue(haar_b)
  );

  // Memory models: data returns one cycle after the read strobe
  always_ff @(posedge clk) begin
    if (rd_a) mdata_a <= mem_a[addr_a];
    if (rd_b) mdata_b <= mem_b[addr_b];
  end

  // Classifier models
  always_comb begin
    v_a    = w0[0] - w0[1] - w0[2] + w0[3];
    haar_a = (v_a > w0[12]) ? w0[14] : w0[13];
    v_b    = w1[0] - w1[1] - w1[2] + w1[3];
    haar_b = (v_b > w1[12]) ? w1[14] : w1[13];
  end

  logic        sel_g;
  logic        done_s, busy_s, rd_s, face_s;
  logic [11:0] addr_s;
  logic [3:0]  fs_s;
  logic [7:0]  rect_or_a;

  always_comb begin
    done_s = sel_g ? done_b : done_a;
    busy_s = sel_g ? busy_b : busy_a;
    rd_s   = sel_g ? rd_b   : rd_a;
    face_s = sel_g ? face_b : face_a;
    addr_s = sel_g ? addr_b : addr_a;
    fs_s   = sel_g ? {3'b000, fs_b} : fs_a;
    rect_or_a = '0;
    for (int k = 0; k < 15; k++) rect_or_a = rect_or_a | w0[k];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  logic [7:0] last_rec [15];
  logic [7:0] hold_exp [15];

  task automatic put(input bit sel, input int a, input logic [7:0] v);
    if (sel) mem_b[a] = v;
    else     mem_a[a] = v;
  endtask

  task automatic put_hdr(input bit sel, inout int a, input logic [7:0] n, input logic [7:0] t);
    put(sel, a, n);
    put(sel, a + 1, t);
    a += 2;
  endtask

  task automatic put_rec(input bit sel, inout int a, input logic [7:0] a1, input logic [7:0] thr,
                         input logic [7:0] lft, input logic [7:0] rgt, input logic [7:0] fill);
    logic [7:0] r [15];
    r[0] = a1; r[1] = 8'd0; r[2] = 8'd0; r[3] = 8'd0;
    for (int k = 4; k < 12; k++) r[k] = fill + 8'(k);
    r[12] = thr; r[13] = lft; r[14] = rgt;
    for (int k = 0; k < 15; k++) begin
      put(sel, a + k, r[k]);
      if (!sel) last_rec[k] = r[k];
    end
    a += 15;
  endtask

  task automatic set_start(input logic v);
    if (sel_g) start_b = v;
    else       start_a = v;
  endtask

  task automatic check_hold(input string tag);
    int mm = 0;
    for (int k = 0; k < 15; k++) if (w0[k] !== hold_exp[k]) mm++;
    check_val(tag, mm, 0);
  endtask

  // One window evaluation: start, count cycles and reads, check results
  task automatic run(input bit sel, input bit poke, input int exp_lat, input int exp_rd,
                     input logic exp_face, input int exp_fs, input string tag);
    int cyc, rds, extra, busy_after;
    sel_g = sel;
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    cyc = 1;
    rds = 0;
    check_val({tag, ".busy1"}, busy_s, 1);
    check_val({tag, ".rd1"}, rd_s, 1);
    check_val({tag, ".addr1"}, addr_s, 0);
    while (!done_s && cyc < 2000) begin
      if (rd_s) rds++;
      set_start(poke && cyc == 5);
      @(negedge clk);
      cyc++;
    end
    set_start(1'b0);
    check_val({tag, ".latency"}, cyc, exp_lat);
    check_val({tag, ".reads"}, rds, exp_rd);
    check_val({tag, ".last_addr"}, addr_s, exp_rd);
    check_val({tag, ".busy_at_done"}, busy_s, 0);
    check_val({tag, ".face"}, face_s, exp_face);
    check_val({tag, ".fail_stage"}, fs_s, exp_fs);
    if (poke) begin
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      extra = 0;
      busy_after = 0;
      repeat (40) begin
        if (done_s) extra++;
        if (busy_s) busy_after++;
        @(negedge clk);
      end
      check_val({tag, ".extra_done"}, extra, 0);
      check_val({tag, ".busy_after"}, busy_after, 0);
    end else begin
      repeat (3) @(negedge clk);
    end
    check_val({tag, ".face_held"}, face_s, exp_face);
  endtask

  // Load the all-pass 4-stage cascade into memory A
  task automatic load_all_pass();
    int a = 0;
    put_hdr(0, a, 2, 15);
    put_rec(0, a, 10, 5, 0, 9, 8'h10);
    put_rec(0, a, 10, 5, 0, 7, 8'h18);
    put_hdr(0, a, 1, 0);
    put_rec(0, a, 10, 5, 0, 1, 8'h20);
    put_hdr(0, a, 1, 100);
    put_rec(0, a, 10, 5, 0, 200, 8'h28);
    put_hdr(0, a, 3, 20);
    put_rec(0, a, 2, 5, 10, 0, 8'h30);
    put_rec(0, a, 10, 5, 0, 6, 8'h38);
    put_rec(0, a, 1, 5, 5, 0, 8'h40);
    for (int k = 0; k < 15; k++) hold_exp[k] = last_rec[k];
  endtask

  initial begin
    int a;
    int dones;
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    sel_g   = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst.busy_a", busy_a, 0);
    check_val("rst.done_a", done_a, 0);
    check_val("rst.rd_a", rd_a, 0);
    check_val("rst.addr_a", addr_a, 0);
    check_val("rst.face_a", face_a, 0);
    check_val("rst.fs_a", fs_a, 0);
    check_val("rst.rect_a", rect_or_a, 0);
    check_val("rst.busy_b", busy_b, 0);
    check_val("rst.fs_b", fs_b, 0);
    reset = 1'b0;

    // Single stage, feature value above its threshold -> right leaf 9 > 5
    a = 0;
    put_hdr(1, a, 1, 5);
    put_rec(1, a, 10, 5, 0, 9, 8'h10);
    run(1, 0, 22, 17, 1'b1, 1, "b_pass");

    // Single stage, value below threshold -> left leaf 3, 3 > 5 false
    a = 0;
    put_hdr(1, a, 1, 5);
    put_rec(1, a, 2, 5, 3, 9, 8'h10);
    run(1, 0, 22, 17, 1'b0, 0, "b_fail");

    // 8-bit accumulator, 40 features of 255: saturates at 255
    a = 0;
    put_hdr(1, a, 40, 254);
    repeat (40) put_rec(1, a, 10, 0, 0, 255, 8'h20);
    run(1, 0, 685, 602, 1'b1, 1, "b_sat");
    mem_b[1] = 8'd255;
    run(1, 0, 685, 602, 1'b0, 0, "b_sat_eq");

    // Four stages, all pass; start pulses during busy and in the done cycle
    load_all_pass();
    run(0, 1, 136, 113, 1'b1, 4, "a_pass");
    check_hold("a_pass.hold");

    // Stage 1 fails with sum equal to threshold, stage 2 is N=0 T=0
    a = 0;
    put_hdr(0, a, 1, 5);
    put_rec(0, a, 10, 5, 0, 9, 8'h50);
    put_hdr(0, a, 1, 5);
    put_rec(0, a, 2, 5, 5, 99, 8'h60);
    for (int k = 0; k < 15; k++) hold_exp[k] = last_rec[k];
    put_hdr(0, a, 0, 0);
    put_hdr(0, a, 1, 0);
    put_rec(0, a, 10, 5, 0, 9, 8'h70);
`ifdef HAAR_EARLY_EXIT_EN
    run(0, 0, 43, 34, 1'b0, 1, "a_fail1");
`else
    for (int k = 0; k < 15; k++) hold_exp[k] = last_rec[k];
    run(0, 0, 68, 53, 1'b0, 1, "a_fail1");
`endif
    check_hold("a_fail1.hold");

    // First stage empty with T=0 fails; later stages still read correctly
    a = 0;
    put_hdr(0, a, 0, 0);
    put_hdr(0, a, 1, 0);
    put_rec(0, a, 10, 5, 0, 9, 8'h80);
    put_hdr(0, a, 1, 0);
    put_rec(0, a, 10, 5, 0, 9, 8'h88);
    put_hdr(0, a, 1, 0);
    put_rec(0, a, 10, 5, 0, 9, 8'h90);
`ifdef HAAR_EARLY_EXIT_EN
    run(0, 0, 5, 2, 1'b0, 0, "a_empty0");
`else
    for (int k = 0; k < 15; k++) hold_exp[k] = last_rec[k];
    run(0, 0, 68, 53, 1'b0, 0, "a_empty0");
    check_hold("a_empty0.hold");
`endif

    // Reset during LOAD cycle 7 of the first stage
    load_all_pass();
    sel_g = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    check_val("mid.rd_before", rd_a, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("mid.busy", busy_a, 0);
    check_val("mid.done", done_a, 0);
    check_val("mid.rd", rd_a, 0);
    check_val("mid.addr", addr_a, 0);
    check_val("mid.rect", rect_or_a, 0);
    check_val("mid.fs", fs_a, 0);
    dones = 0;
    repeat (200) begin
      if (done_a || busy_a) dones++;
      @(negedge clk);
    end
    check_val("mid.no_done", dones, 0);
    run(0, 0, 136, 113, 1'b1, 4, "a_after_rst");
    check_hold("a_after_rst.hold");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
